// File: rtl/chinpo_ctrl_gen2.sv
// chinpo_ctrl_gen2: CHINPO multicycle control FSM with prioritised maskable interrupts; define CHINPO_CTRL_WAIT_EN for memory wait states
module chinpo_ctrl_gen2 #(
  parameter int NINT = 4,
  parameter int IDW  = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [3:0]      i_opcode,
  input  logic            i_ir0,
  input  logic            i_ir1,
  input  logic            i_ir2,
  input  logic            i_ir3,
  input  logic            i_branch,
  input  logic [NINT-1:0] i_int_req,
  input  logic [NINT-1:0] i_int_mask,
  input  logic            i_int_ret,
  input  logic            i_mem_ready,
  output logic            o_pc_write,
  output logic            o_ir_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_reg_write,
  output logic            o_write_data_src,
  output logic            o_alu_src_a,
  output logic            o_clra,
  output logic            o_clrb,
  output logic            o_mva,
  output logic            o_mvb,
  output logic            o_mem_data,
  output logic [2:0]      o_alu_src_b,
  output logic [1:0]      o_alu_op,
  output logic [1:0]      o_mem_addr,
  output logic [1:0]      o_pc_in,
  output logic [NINT-1:0] o_int_ack,
  output logic [IDW-1:0]  o_int_id,
  output logic            o_ie,
  output logic [3:0]      o_current_state,
  output logic [3:0]      o_next_state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, DR, I_ST, MEMA, BEQ, J, JR,
    DR_WRITE, SW_WRITE, LW_READ, LW_WRITE, JAL, RESET_ST, INT_SAVE, INT_VEC
  } state_t;

  state_t          r_state, w_next, w_bound;
  logic [NINT-1:0] r_pending, w_avail;
  logic [IDW-1:0]  r_int_id, w_sel;
  logic            r_ie, w_take, w_ready;

`ifdef CHINPO_CTRL_WAIT_EN
  assign w_ready = i_mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = i_mem_ready;
  assign w_ready = 1'b1;
`endif

  assign w_avail         = r_pending & ~i_int_mask;
  assign w_take          = r_ie & |w_avail;
  assign w_bound         = w_take ? INT_SAVE : FETCH;
  assign o_int_ack       = (r_state == INT_VEC) ? (NINT'(1) << r_int_id) : '0;
  assign o_int_id        = r_int_id;
  assign o_ie            = r_ie;
  assign o_current_state = r_state;
  assign o_next_state    = w_next;

  // lowest-index unmasked pending channel wins
  always_comb begin
    w_sel = '0;
    for (int i = NINT - 1; i >= 0; i--)
      if (w_avail[i]) w_sel = IDW'(i);
  end

  // next-state decode; instruction ends are the only interrupt points
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    w_next = w_ready ? DECODE : FETCH;
      DECODE:
        case (i_opcode)
          4'd3:                    w_next = JR;
          4'd4, 4'd9, 4'd10, 4'd13: w_next = I_ST;
          4'd8, 4'd11:             w_next = J;
          4'd14, 4'd15:            w_next = MEMA;
          4'd12:                   w_next = i_branch ? BEQ : w_bound;
          default:                 w_next = DR;
        endcase
      DR, I_ST: w_next = DR_WRITE;
      MEMA:     w_next = (i_opcode == 4'd15) ? SW_WRITE : LW_READ;
      LW_READ:  w_next = w_ready ? LW_WRITE : LW_READ;
      SW_WRITE: w_next = w_ready ? w_bound : SW_WRITE;
      JR:       w_next = J;
      J:        w_next = (i_opcode == 4'd11) ? JAL : w_bound;
      BEQ, DR_WRITE, LW_WRITE, JAL: w_next = w_bound;
      RESET_ST: w_next = FETCH;
      INT_SAVE: w_next = w_ready ? INT_VEC : INT_SAVE;
      INT_VEC:  w_next = FETCH;
    endcase
  end

  // per-state datapath controls; Fetch strobes qualify on memory ready
  always_comb begin
    {o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_reg_write, o_write_data_src,
     o_alu_src_a, o_clra, o_clrb, o_mva, o_mvb, o_mem_data} = '0;
    o_alu_src_b = '0;
    o_alu_op    = '0;
    o_mem_addr  = '0;
    o_pc_in     = '0;
    case (r_state)
      FETCH: begin
        o_pc_write  = w_ready;
        o_ir_write  = w_ready;
        o_mem_read  = 1'b1;
        o_alu_src_b = 3'd4;
      end
      DECODE: o_alu_src_b = 3'd3;
      DR: begin
        o_alu_op = 2'd2;
        o_alu_src_a = 1'b1;
        {o_mva, o_mvb, o_clra, o_clrb} = {i_ir3, i_ir2, i_ir1, i_ir0};
      end
      I_ST: begin
        o_alu_op    = 2'd2;
        o_alu_src_a = 1'b1;
        o_alu_src_b = 3'd1;
      end
      MEMA: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 3'd3;
      end
      BEQ: o_pc_write = 1'b1;
      J: begin
        o_pc_write = 1'b1;
        o_alu_op   = 2'd3;
        o_pc_in    = 2'd1;
      end
      JR: begin
        o_alu_src_a = 1'b1;
        o_alu_op = 2'd3;
        {o_mva, o_mvb, o_clra, o_clrb} = {i_ir3, i_ir2, i_ir1, i_ir0};
      end
      DR_WRITE, JAL: o_reg_write = 1'b1;
      SW_WRITE: begin
        o_mem_addr  = 2'd1;
        o_mem_write = 1'b1;
      end
      LW_READ: begin
        o_mem_addr = 2'd1;
        o_mem_read = 1'b1;
      end
      LW_WRITE: begin
        o_reg_write      = 1'b1;
        o_write_data_src = 1'b1;
      end
      INT_SAVE: begin
        o_mem_write = 1'b1;
        o_mem_addr  = 2'd3;
        o_mem_data  = 1'b1;
      end
      INT_VEC: begin
        o_pc_write = 1'b1;
        o_pc_in    = 2'd3;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= RESET_ST;
    else r_state <= w_next;

  // pending latches: new requests set, the serviced channel clears in IntVec, set wins
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_pending <= '0;
    else r_pending <= (r_pending & ~o_int_ack) | i_int_req;

  // capture serviced channel only on entry to IntSave so later arrivals cannot redirect it
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_int_id <= '0;
    else if (r_state != INT_SAVE && w_next == INT_SAVE) r_int_id <= w_sel;

  // global enable: cleared entering and during IntVec (beats a coincident return), set by return
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_ie <= 1'b1;
    else if ((r_state == INT_SAVE && w_next == INT_VEC) || r_state == INT_VEC) r_ie <= 1'b0;
    else if (i_int_ret) r_ie <= 1'b1;
endmodule

// File: tb/tb_chinpo_ctrl_gen2.sv
// tb_chinpo_ctrl_gen2: vector-table and scoreboard bench for chinpo_ctrl_gen2
module tb_chinpo_ctrl_gen2;
  localparam logic [3:0] F = 4'd0, D = 4'd1, DR = 4'd2, I = 4'd3, MA = 4'd4, BQ = 4'd5, J = 4'd6, JR = 4'd7;
  localparam logic [3:0] DRW = 4'd8, SWW = 4'd9, LWR = 4'd10, LWW = 4'd11, JAL = 4'd12, RST = 4'd13, ISV = 4'd14, IVC = 4'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ir0, ir1, ir2, ir3, branch, int_ret, mem_ready;
  logic [3:0] opcode, int_req, int_mask;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, wds, alu_src_a, clra, clrb, mva, mvb, mem_data, ie;
  logic [2:0] alu_src_b;
  logic [1:0] alu_op, mem_addr, pc_in, int_id;
  logic [3:0] int_ack, cur_state, nxt_state;
  logic [20:0] act;
  logic [1:0] exp_id;
  logic [3:0] sb[$];
  int checks = 0, failures = 0;

  assign act = {pc_write, ir_write, mem_read, mem_write, reg_write, wds, alu_src_a, clra, clrb, mva, mvb, mem_data,
                alu_src_b, alu_op, mem_addr, pc_in};

  chinpo_ctrl_gen2 #(.NINT(4), .IDW(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_opcode(opcode), .i_ir0(ir0), .i_ir1(ir1), .i_ir2(ir2), .i_ir3(ir3),
    .i_branch(branch), .i_int_req(int_req), .i_int_mask(int_mask), .i_int_ret(int_ret), .i_mem_ready(mem_ready),
    .o_pc_write(pc_write), .o_ir_write(ir_write), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_reg_write(reg_write), .o_write_data_src(wds), .o_alu_src_a(alu_src_a), .o_clra(clra), .o_clrb(clrb),
    .o_mva(mva), .o_mvb(mvb), .o_mem_data(mem_data), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
    .o_mem_addr(mem_addr), .o_pc_in(pc_in), .o_int_ack(int_ack), .o_int_id(int_id), .o_ie(ie),
    .o_current_state(cur_state), .o_next_state(nxt_state)
  );

  typedef struct {
    logic [3:0]  op;
    logic        br;
    logic [3:0]  ir;
    int          n;
    logic [23:0] seq;
  } vec_t;
  vec_t vt[14];

  function automatic logic [20:0] exp_ctl(logic [3:0] s, logic [3:0] ir, logic rdy);
    logic pcw, irw, mr, mw, rw, wd, asa, ca, cb, ma, mb, md;
    logic [2:0] asb;
    logic [1:0] aop, madr, pci;
    {pcw, irw, mr, mw, rw, wd, asa, ca, cb, ma, mb, md, asb, aop, madr, pci} = '0;
    case (s)
      F:   begin pcw = rdy; irw = rdy; mr = 1'b1; asb = 3'd4; end
      D:   asb = 3'd3;
      DR:  begin aop = 2'd2; asa = 1'b1; {ma, mb, ca, cb} = ir; end
      I:   begin aop = 2'd2; asa = 1'b1; asb = 3'd1; end
      MA:  begin asa = 1'b1; asb = 3'd3; end
      BQ:  pcw = 1'b1;
      J:   begin pcw = 1'b1; aop = 2'd3; pci = 2'd1; end
      JR:  begin asa = 1'b1; aop = 2'd3; {ma, mb, ca, cb} = ir; end
      DRW, JAL: rw = 1'b1;
      SWW: begin madr = 2'd1; mw = 1'b1; end
      LWR: begin madr = 2'd1; mr = 1'b1; end
      LWW: begin rw = 1'b1; wd = 1'b1; end
      ISV: begin mw = 1'b1; madr = 2'd3; md = 1'b1; end
      IVC: begin pcw = 1'b1; pci = 2'd3; end
      default: ;
    endcase
    return {pcw, irw, mr, mw, rw, wd, asa, ca, cb, ma, mb, md, asb, aop, madr, pci};
  endfunction

  task automatic ck(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk(string nm);
    logic [3:0] e;
    if (sb.size() == 0) begin
      ck({nm, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    ck({nm, " state"}, cur_state, e);
    ck({nm, " ctl"}, act, exp_ctl(e, {ir3, ir2, ir1, ir0}, mem_ready));
    if (e == IVC) begin
      ck({nm, " ack"}, int_ack, 4'(1) << exp_id);
      ck({nm, " id"}, int_id, exp_id);
    end
    @(negedge clk);
  endtask

  task automatic step(logic [3:0] s, string nm);
    sb.push_back(s);
    chk(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'd0,  1'b0, 4'b0000, 4, 24'h012800};
    vt[1]  = '{4'd3,  1'b0, 4'b0101, 4, 24'h017600};
    vt[2]  = '{4'd4,  1'b0, 4'b0000, 4, 24'h013800};
    vt[3]  = '{4'd8,  1'b0, 4'b0000, 3, 24'h016000};
    vt[4]  = '{4'd11, 1'b0, 4'b0000, 4, 24'h016C00};
    vt[5]  = '{4'd14, 1'b0, 4'b0000, 5, 24'h014AB0};
    vt[6]  = '{4'd15, 1'b0, 4'b0000, 4, 24'h014900};
    vt[7]  = '{4'd12, 1'b1, 4'b0000, 3, 24'h015000};
    vt[8]  = '{4'd12, 1'b0, 4'b0000, 2, 24'h010000};
    vt[9]  = '{4'd13, 1'b0, 4'b0000, 4, 24'h013800};
    vt[10] = '{4'd7,  1'b0, 4'b1010, 4, 24'h012800};
    vt[11] = '{4'd9,  1'b0, 4'b0000, 4, 24'h013800};
    vt[12] = '{4'd10, 1'b0, 4'b0000, 4, 24'h013800};
    vt[13] = '{4'd5,  1'b0, 4'b1111, 4, 24'h012800};
    rst_n = 1'b0; opcode = '0; {ir3, ir2, ir1, ir0} = '0; branch = 1'b0;
    int_req = '0; int_mask = '0; int_ret = 1'b0; mem_ready = 1'b1; exp_id = '0;
    @(negedge clk);
    ck("reset state", cur_state, RST);
    ck("reset ctl", act, 0);
    ck("reset ie", ie, 1);
    ck("reset id", int_id, 0);
    ck("reset ack", int_ack, 0);
    ck("reset next", nxt_state, F);
    rst_n = 1'b1;
    step(RST, "rel");
    foreach (vt[v]) begin
      opcode = vt[v].op;
      branch = vt[v].br;
      {ir3, ir2, ir1, ir0} = vt[v].ir;
      for (int k = 0; k < vt[v].n; k++) sb.push_back(vt[v].seq[23-4*k -: 4]);
      while (sb.size() > 0) chk($sformatf("vec%0d", v));
    end
    opcode = 4'd0; branch = 1'b0; {ir3, ir2, ir1, ir0} = '0;
    step(F, "irq"); step(D, "irq");
    int_req = 4'b0110;
    step(DR, "irq");
    int_req = '0;
    step(DRW, "irq"); step(ISV, "irq");
    exp_id = 2'd1;
    step(IVC, "irq");
    ck("irq ie after vec", ie, 0);
    opcode = 4'd8;
    int_req = 4'b0001;
    step(F, "ie0"); int_req = '0;
    step(D, "ie0"); step(J, "ie0");
    int_ret = 1'b1;
    step(F, "ie0 no entry");
    int_ret = 1'b0;
    step(D, "ret"); step(J, "ret"); step(ISV, "ret");
    exp_id = 2'd0;
    int_ret = 1'b1;
    step(IVC, "ret");
    int_ret = 1'b0;
    ck("ret in vec ie", ie, 0);
    int_ret = 1'b1;
    step(F, "pend2"); int_ret = 1'b0;
    step(D, "pend2"); step(J, "pend2"); step(ISV, "pend2");
    exp_id = 2'd2;
    step(IVC, "pend2");
    int_ret = 1'b1;
    step(F, "mask"); int_ret = 1'b0;
    step(D, "mask"); step(J, "mask");
    int_mask = 4'b0001; int_req = 4'b0001;
    step(F, "mask"); int_req = '0;
    step(D, "mask"); step(J, "mask");
    step(F, "masked"); step(D, "masked");
    int_mask = '0;
    step(J, "unmask"); step(ISV, "unmask");
    exp_id = 2'd0;
    step(IVC, "unmask");
    opcode = 4'd0;
    step(F, "mid"); step(D, "mid");
    int_req = 4'b1000; rst_n = 1'b0;
    #1;
    ck("mid reset state", cur_state, RST);
    ck("mid reset ctl", act, 0);
    ck("mid reset ie", ie, 1);
    @(negedge clk);
    int_req = '0; rst_n = 1'b1;
    step(RST, "post"); opcode = 4'd8;
    step(F, "post"); step(D, "post"); step(J, "post");
    step(F, "post no entry"); step(D, "post"); step(J, "post");
`ifdef CHINPO_CTRL_WAIT_EN
    mem_ready = 1'b0;
    repeat (3) step(F, "wait");
    mem_ready = 1'b1;
    step(F, "wait rdy"); step(D, "wait"); step(J, "wait");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chinpo_ctrl_gen2.md
Name: chinpo_ctrl_gen2

Overview:
- Next-generation multicycle control FSM for the CHINPO datapath.
- Keeps the 4-bit opcode decode and per-state control outputs.
- Adds NINT prioritised, maskable interrupt channels with pending latches, a global interrupt-enable with return handshake, and a two-state interrupt entry (save PC, then vector).
- Optionally adds memory wait-state handling.
- Sits between the instruction register / branch compare and the datapath muxes, register file and memory.

Parameters:
- NINT, 4, number of interrupt channels (1..16); channel 0 has highest priority.
- IDW, 2, width of IntId; must equal max(1, ceil(log2(NINT))).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Opcode  in  4  IR[15:12].
- IR0..IR3  in  1 each  DR/JR operand-modifier bits.
- Branch  in  1  BEQ compare true.
- IntReq  in  NINT  level interrupt requests.
- IntMask  in  NINT  1 = channel masked.
- IntRet  in  1  one-cycle pulse from datapath on return-from-interrupt.
- MemReady  in  1  memory access complete (used only with CTRL_WAIT_EN).
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, WriteDataSrc, ALUSrcA, CLRA, CLRB, MVA, MVB, MemData  out  1 each  datapath controls.
- ALUSrcB  out  3;  ALUOp  out  2;  MemAddr  out  2;  PcIn  out  2  mux/ALU selects.
- IntAck  out  NINT  one-hot acknowledge, asserted in IntVec only.
- IntId  out  IDW  index of the channel being serviced.
- IE  out  1  global interrupt enable.
- current_state, next_state  out  4  debug.

Behaviour:
- Reset low: current_state=RESET_STATE(13), pending=0, IE=1, IntId=0. All 1-bit outputs are 0; selects are 0.
- States: Fetch0 Decode1 DR2 I3 MemA4 BEQ5 J6 JR7 DR_Write8 SW_Write9 LW_Read10 LW_Write11 JAL12 RESET13 IntSave14 IntVec15.
- Per-state outputs; anything unlisted is 0.
  - Fetch: IRWrite, PCWrite, MemRead; ALUSrcB=4.
  - Decode: ALUSrcB=3.
  - DR: ALUOp=2; ALUSrcA=1; MVA/MVB/CLRA/CLRB = IR3/IR2/IR1/IR0.
  - I: ALUOp=2; ALUSrcA=1; ALUSrcB=1.
  - MemA: ALUSrcA=1; ALUSrcB=3.
  - BEQ: PCWrite.
  - J: PCWrite; ALUOp=3; PcIn=1.
  - JR: ALUSrcA=1; ALUOp=3; MVA..CLRB as in DR.
  - DR_Write, JAL: RegWrite.
  - SW_Write: MemAddr=1; MemWrite.
  - LW_Read: MemAddr=1; MemRead.
  - LW_Write: RegWrite; WriteDataSrc=1.
  - IntSave: MemWrite; MemAddr=3; MemData=1.
  - IntVec: PCWrite; PcIn=3; IntAck[IntId]=1.
- Decode transitions:
  - 3 -> JR.
  - 4, 9, 10, 13 -> I.
  - Other opcodes <8 -> DR.
  - 8, 11 -> J.
  - 14, 15 -> MemA.
  - 12 with Branch -> BEQ.
  - Otherwise -> BOUND.
- Other transitions:
  - DR, I -> DR_Write.
  - MemA -> SW_Write if Opcode=15, else LW_Read.
  - LW_Read -> LW_Write.
  - JR -> J.
  - J -> JAL if Opcode=11, else BOUND.
  - BEQ, DR_Write, SW_Write, LW_Write, JAL -> BOUND.
  - RESET -> Fetch.
  - IntSave -> IntVec.
  - IntVec -> Fetch.
- BOUND = IntSave if take, else Fetch.
  - take = IE & |(pending & ~IntMask).
  - JR->J and Decode->J are never interrupt points.
- Pending:
  - pending[i] is set on any clock where IntReq[i]=1.
  - It is cleared only in the IntVec cycle, for i=IntId (set wins if IntReq[IntId] is still high).
- Selection:
  - On the BOUND->IntSave transition, IntId latches the lowest-index bit of pending & ~IntMask.
  - IntId is held through IntVec; later higher-priority arrivals do not change it.
- IE:
  - Cleared on entry to IntVec.
  - Set on IntRet.
  - If IntRet coincides with IntVec, clear wins.
- Masking a pending channel suppresses it without clearing it; unmasking later services it.
- Reset asserted mid-instruction or mid-entry aborts to RESET_STATE and clears pending.

Optional Feature:
- Macro: CHINPO_CTRL_WAIT_EN.
- Defined:
  - Fetch, SW_Write, LW_Read and IntSave hold state until MemReady=1.
  - While waiting, MemRead/MemWrite stay asserted.
  - PCWrite and IRWrite in Fetch are asserted only in the MemReady=1 cycle (Mealy).
  - The interrupt decision is made in the cycle the wait state exits.
- Undefined: every state is exactly one cycle and MemReady is ignored.

Test Plan:
- Reset low mid-DR, release -> RESET(13), then Fetch(0); pending=0, IE=1, all strobes 0.
- Opcode=15 -> Fetch, Decode, MemA, SW_Write(MemWrite=1, MemAddr=1), Fetch; Opcode=14 -> LW_Read, LW_Write(RegWrite=1, WriteDataSrc=1).
- IntReq=4'b0110, IntMask=0, during DR -> after DR_Write: IntSave(MemAddr=3), IntVec(IntAck=0010, IntId=1, PcIn=3), Fetch; IE=0; pending=0100.
- IE=0, IntReq[0] pulsed -> no entry; IntRet pulse -> entry at next boundary with IntId=0; IntRet in the IntVec cycle leaves IE=0.
- IntMask=4'b0001, IntReq[0]=1 -> never serviced; clear mask -> serviced at next boundary, pending[0] retained meanwhile.
- CHINPO_CTRL_WAIT_EN, MemReady low 3 cycles in Fetch -> 3 extra Fetch cycles with PCWrite=0; PCWrite=IRWrite=1 only in the MemReady=1 cycle.
